// File: rtl/flake_spawner.sv
// flake_spawner: pool of falling snowflakes fed by the LFSR word; one slot walked per cycle after each frame_tick.
// Ports: clk/rst (async high), enable, frame_tick, rnd, level, hit_valid/hit_idx in; rd_idx -> rd_x/rd_y/rd_active (comb read),
//        active_count, busy, miss_pulse, spawn_drop, overrun out. Walk latency N+2 cycles from tick; ticks during a walk are dropped.
module flake_spawner #(
  parameter int NUM_FLAKES = 8,
  parameter int X_LIMIT    = 624,
  parameter int Y_MAX      = 480,
  parameter int SPAWN_BASE = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          frame_tick,
  input  logic [23:0]                   rnd,
  input  logic [3:0]                    level,
  input  logic                          hit_valid,
  input  logic [$clog2(NUM_FLAKES)-1:0] hit_idx,
  input  logic [$clog2(NUM_FLAKES)-1:0] rd_idx,
  output logic [9:0]                    rd_x,
  output logic [8:0]                    rd_y,
  output logic                          rd_active,
  output logic [4:0]                    active_count,
  output logic                          busy,
  output logic                          miss_pulse,
  output logic                          spawn_drop,
  output logic                          overrun
);

  localparam int IW = $clog2(NUM_FLAKES);
  localparam int CW = $clog2(SPAWN_BASE + 1);

  typedef enum logic [1:0] {IDLE, RUN, UPDATE, SPAWN} state_t;

  state_t                  state;
  logic [IW-1:0]           idx_q;
  logic [CW-1:0]           cnt_q;
  logic [9:0]              x_q   [NUM_FLAKES];
  logic [8:0]              y_q   [NUM_FLAKES];
  logic [2:0]              spd_q [NUM_FLAKES];
  logic [NUM_FLAKES-1:0]   act_q;

  // Combinational next-state helpers
  int                      reload_i;
  logic [CW-1:0]           reload;
  logic [CW-1:0]           cnt_eff;
  logic                    spawn_due;
  logic [9:0]              y_next;
  logic                    upd_retire;
  logic                    hit_on_upd;
  logic                    free_found;
  logic [IW-1:0]           free_idx;
  logic                    spawn_load;
  logic [9:0]              rx;
  logic [9:0]              x_new;
  logic [2:0]              spd_new;
  logic [NUM_FLAKES-1:0]   act_n;
  logic [4:0]              pop_n;
  logic                    unused_rnd;

  assign unused_rnd = ^rnd[23:12];

  assign rd_x      = x_q[rd_idx];
  assign rd_y      = y_q[rd_idx];
  assign rd_active = act_q[rd_idx];

  always_comb begin
    reload_i = SPAWN_BASE - 2 * int'(level);
    if (reload_i < 2) reload_i = 2;
  end
  assign reload = CW'(reload_i);

  // A level raise shortens a pending wait immediately rather than after the
  // current (longer) countdown expires.
  assign cnt_eff   = (cnt_q > reload) ? reload : cnt_q;
  assign spawn_due = (state == SPAWN) && (cnt_eff == CW'(1));

  // 10-bit sum so a flake near the bottom cannot wrap back to the top.
  assign y_next     = {1'b0, y_q[idx_q]} + {7'd0, spd_q[idx_q]};
  assign upd_retire = (state == UPDATE) && act_q[idx_q] && (y_next >= 10'(Y_MAX));
  assign hit_on_upd = hit_valid && (state == UPDATE) && (hit_idx == idx_q);

  // Lowest-index free slot: scan downward so the last match wins.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_FLAKES - 1; i >= 0; i--) begin
      if (!act_q[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
  end

  assign spawn_load = spawn_due && free_found;
  assign rx         = rnd[9:0];
  // Out-of-range x folds back into the screen instead of clamping to the edge.
  assign x_new      = (rx > 10'(X_LIMIT)) ? rx - 10'(X_LIMIT + 1) : rx;
  assign spd_new    = 3'd1 + {1'b0, rnd[11:10]};

  // A hit overrides both a bottom retire and a fresh spawn on the same slot.
  always_comb begin
    act_n = act_q;
    if (upd_retire) act_n[idx_q]    = 1'b0;
    if (spawn_load) act_n[free_idx] = 1'b1;
    if (hit_valid)  act_n[hit_idx]  = 1'b0;
  end

  always_comb begin
    pop_n = '0;
    for (int i = 0; i < NUM_FLAKES; i++) pop_n = pop_n + 5'(act_n[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx_q        <= '0;
      cnt_q        <= CW'(SPAWN_BASE);
      act_q        <= '0;
      active_count <= '0;
      busy         <= 1'b0;
      miss_pulse   <= 1'b0;
      spawn_drop   <= 1'b0;
      overrun      <= 1'b0;
      for (int i = 0; i < NUM_FLAKES; i++) begin
        x_q[i]   <= '0;
        y_q[i]   <= '0;
        spd_q[i] <= '0;
      end
    end else begin
      act_q      <= act_n;
      miss_pulse <= upd_retire && !hit_on_upd;
      spawn_drop <= spawn_due && !free_found;

      if (hit_valid || state == SPAWN) active_count <= pop_n;

      if (frame_tick && (state == UPDATE || state == SPAWN)) overrun <= 1'b1;

      if (state == UPDATE && act_q[idx_q] && !upd_retire) y_q[idx_q] <= y_next[8:0];

      if (spawn_load) begin
        x_q[free_idx]   <= x_new;
        y_q[free_idx]   <= '0;
        spd_q[free_idx] <= spd_new;
      end

      if (state == SPAWN) cnt_q <= spawn_due ? reload : cnt_eff - CW'(1);

      case (state)
        IDLE: if (enable) state <= RUN;
        RUN: begin
          if (!enable) begin
            state <= IDLE;
          end else if (frame_tick) begin
            state <= UPDATE;
            idx_q <= '0;
            busy  <= 1'b1;
          end
        end
        UPDATE: begin
          if (idx_q == IW'(NUM_FLAKES - 1)) state <= SPAWN;
          else                              idx_q <= idx_q + IW'(1);
        end
        SPAWN: begin
          busy  <= 1'b0;
          state <= enable ? RUN : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flake_spawner.sv
// tb_flake_spawner: directed scoreboard bench for flake_spawner.
// Expectations are queued as stimulus is applied and popped when the DUT output is sampled (posedge + 1).
module tb_flake_spawner;

  logic        clk = 1'b0;
  logic        rst, enable, frame_tick, hit_valid;
  logic [23:0] rnd;
  logic [3:0]  level;
  logic [2:0]  hit_idx, rd_idx;
  logic [9:0]  rd_x;
  logic [8:0]  rd_y;
  logic        rd_active;
  logic [4:0]  active_count;
  logic        busy, miss_pulse, spawn_drop, overrun;

  flake_spawner dut (
    .clk(clk), .rst(rst), .enable(enable), .frame_tick(frame_tick),
    .rnd(rnd), .level(level), .hit_valid(hit_valid), .hit_idx(hit_idx),
    .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y), .rd_active(rd_active),
    .active_count(active_count), .busy(busy), .miss_pulse(miss_pulse),
    .spawn_drop(spawn_drop), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int miss_cnt = 0;
  int drop_cnt = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  always @(negedge clk) begin
    if (miss_pulse === 1'b1) miss_cnt++;
    if (spawn_drop === 1'b1) drop_cnt++;
  end

  task automatic push(input string t, input logic [31:0] v);
    exp_q.push_back(v);
    tag_q.push_back(t);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    logic [31:0] e;
    string       t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", t, obs, e);
    end
  endtask

  task automatic rd(input int i, output logic [31:0] x, output logic [31:0] y, output logic [31:0] a);
    rd_idx = 3'(i);
    #1;
    x = 32'(rd_x);
    y = 32'(rd_y);
    a = 32'(rd_active);
  endtask

  // One frame tick; c counts cycles after the sampling edge (c=1 updates slot 0).
  task automatic do_tick(input int extra_at, input int hit_at, input int hit_slot,
                         input int drop_at, output logic bs);
    bs = 1'b0;
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 1) bs = busy;
      if (c == hit_at) begin hit_valid = 1'b1; hit_idx = 3'(hit_slot); end
      if (c == extra_at) frame_tick = 1'b1;
      if (c == drop_at) enable = 1'b0;
      @(posedge clk); #1;
      hit_valid  = 1'b0;
      frame_tick = 1'b0;
    end
  endtask

  task automatic hit_now(input int slot);
    @(posedge clk); #1 hit_valid = 1'b1; hit_idx = 3'(slot);
    @(posedge clk); #1 hit_valid = 1'b0;
  endtask

  logic [31:0] x, y, a;
  logic        bs;
  int          miss_base;

  initial begin
    rst = 1'b1; enable = 1'b0; frame_tick = 1'b0; rnd = '0; level = '0;
    hit_valid = 1'b0; hit_idx = '0; rd_idx = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state and ticks while disabled
    push("rst_count", 0); push("rst_busy", 0); push("rst_overrun", 0);
    pop_check(32'(active_count)); pop_check(32'(busy)); pop_check(32'(overrun));
    push("idle_busy", 0); push("idle_count", 0); push("idle_act0", 0);
    do_tick(0, 0, 0, 0, bs);
    do_tick(0, 0, 0, 0, bs);
    pop_check(32'(bs)); pop_check(32'(active_count));
    rd(0, x, y, a); pop_check(a);

    // Level 15: reload 2, first spawn on the second walk
    level = 4'd15; rnd = 24'h0000C5; enable = 1'b1;
    repeat (2) @(posedge clk); #1;
    push("t1_busy", 1); push("t1_act0", 0);
    do_tick(0, 0, 0, 0, bs);
    pop_check(32'(bs)); rd(0, x, y, a); pop_check(a);
    push("t2_x0", 197); push("t2_y0", 0); push("t2_act0", 1); push("t2_count", 1);
    do_tick(0, 0, 0, 0, bs);
    rd(0, x, y, a); pop_check(x); pop_check(y); pop_check(a); pop_check(32'(active_count));
    push("t3_y0", 1); push("t3_act1", 0);
    do_tick(0, 0, 0, 0, bs);
    rd(0, x, y, a); pop_check(y); rd(1, x, y, a); pop_check(a);
    push("t4_act1", 1); push("t4_count", 2);
    do_tick(0, 0, 0, 0, bs);
    rd(1, x, y, a); pop_check(a); pop_check(32'(active_count));

    // Fill the pool: slot k spawns on tick 2+2k, slot 7 on tick 16
    for (int k = 5; k <= 16; k++) do_tick(0, 0, 0, 0, bs);
    push("full_count", 8);
    pop_check(32'(active_count));
    do_tick(0, 0, 0, 0, bs);                  // tick 17
    rnd = 24'h000BE8;                         // a load here would give x=375
    push("drop_cnt", 1); push("drop_count", 8); push("drop_x7", 197);
    push("drop_y7", 2); push("drop_y0", 16);
    do_tick(0, 0, 0, 0, bs);                  // tick 18: spawn due, pool full
    pop_check(32'(drop_cnt)); pop_check(32'(active_count));
    rd(7, x, y, a); pop_check(x); pop_check(y);
    rd(0, x, y, a); pop_check(y);

    // Tick while busy is dropped and overrun sticks
    push("ovr_set", 1); push("ovr_y0", 17);
    do_tick(3, 0, 0, 0, bs);
    pop_check(32'(overrun)); rd(0, x, y, a); pop_check(y);
    push("ovr_held", 1); push("ovr_y0b", 18);
    do_tick(0, 0, 0, 0, bs);
    pop_check(32'(overrun)); rd(0, x, y, a); pop_check(y);

    // Reset in the middle of a walk
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    repeat (2) @(posedge clk); #1;
    push("mid_busy", 1); pop_check(32'(busy));
    rst = 1'b1; #1;
    push("rr_busy", 0); push("rr_count", 0); push("rr_ovr", 0); push("rr_miss", 0);
    push("rr_drop", 0); push("rr_act0", 0); push("rr_x0", 0); push("rr_y0", 0);
    pop_check(32'(busy)); pop_check(32'(active_count)); pop_check(32'(overrun));
    pop_check(32'(miss_pulse)); pop_check(32'(spawn_drop));
    rd(0, x, y, a); pop_check(a); pop_check(x); pop_check(y);
    rnd = 24'h000FE8; level = 4'd15;
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    miss_base = miss_cnt;

    // Wrapped x and speed 4 down to the bottom
    do_tick(0, 0, 0, 0, bs);
    push("w_x0", 375); push("w_y0", 0); push("w_act0", 1);
    do_tick(0, 0, 0, 0, bs);                  // tick 2: slot 0 spawned
    rd(0, x, y, a); pop_check(x); pop_check(y); pop_check(a);
    level = 4'd0;                             // slot 1 at tick 4, then 36, 68, 100
    push("w_y0_t3", 4);
    do_tick(0, 0, 0, 0, bs);
    rd(0, x, y, a); pop_check(y);
    for (int k = 4; k <= 121; k++) do_tick(0, 0, 0, 0, bs);
    push("w_y0_476", 476); push("w_nomiss", 0);
    rd(0, x, y, a); pop_check(y); pop_check(32'(miss_cnt - miss_base));
    push("w_miss1", 1); push("w_act0_off", 0); push("w_count4", 4);
    do_tick(0, 0, 0, 0, bs);                  // tick 122
    pop_check(32'(miss_cnt - miss_base)); rd(0, x, y, a); pop_check(a);
    pop_check(32'(active_count));

    // Hit on the slot being updated beats the bottom retire
    push("h_y1", 476);
    do_tick(0, 0, 0, 0, bs);                  // tick 123
    rd(1, x, y, a); pop_check(y);
    push("h_miss", 1); push("h_act1", 0); push("h_count3", 3);
    do_tick(0, 2, 1, 0, bs);                  // tick 124, hit slot 1 during its update
    pop_check(32'(miss_cnt - miss_base)); rd(1, x, y, a); pop_check(a);
    pop_check(32'(active_count));
    push("h_inactive", 3);
    hit_now(0);
    pop_check(32'(active_count));
    push("h_run_count", 2); push("h_run_act2", 0);
    hit_now(2);
    pop_check(32'(active_count)); rd(2, x, y, a); pop_check(a);

    // enable dropped mid-walk: walk completes, then parked until re-enabled
    push("en_busy", 1); push("en_y3", 228); push("en_idle", 0);
    do_tick(0, 0, 0, 1, bs);
    pop_check(32'(bs)); rd(3, x, y, a); pop_check(y); pop_check(32'(busy));
    push("off_busy", 0); push("off_y3", 228);
    do_tick(0, 0, 0, 0, bs);
    pop_check(32'(bs)); rd(3, x, y, a); pop_check(y);
    enable = 1'b1;
    repeat (2) @(posedge clk); #1;
    push("resume_y3", 232);
    do_tick(0, 0, 0, 0, bs);
    rd(3, x, y, a); pop_check(y);

    total++;
    assert (exp_q.size() == 0) else begin
      bad++;
      $error("FAIL scoreboard_drain: observed=%0d expected=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
